// File: rtl/pca_pkg.sv
// Shared types and helpers for the pivot search engine: FSM state encoding,
// index-width helper and the result bundle layout at the default configuration.
package pca_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    RESULT = 2'd2
  } pse_state_e;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int PSE_DEF_N     = 4;
  localparam int PSE_DEF_W     = 8;
  localparam int PSE_DEF_IDX_W = idx_width(PSE_DEF_N);

  typedef struct packed {
    logic [PSE_DEF_IDX_W-1:0] p;
    logic [PSE_DEF_IDX_W-1:0] q;
    logic [PSE_DEF_W-1:0]     c_pq;
    logic [PSE_DEF_W-1:0]     c_pp;
    logic [PSE_DEF_W-1:0]     c_qq;
    logic                     converged;
  } pse_result_t;

endpackage

// File: rtl/pivot_search_engine_if.sv
// Element stream in, pivot result out. The engine is the slave on this bus.
interface pivot_search_engine_if #(
  parameter int MATRIX_SIZE = 4,
  parameter int DATA_SIZE   = 8,
  localparam int IDX_W      = pca_pkg::idx_width(MATRIX_SIZE)
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_SIZE-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [IDX_W-1:0]     p;
  logic [IDX_W-1:0]     q;
  logic [DATA_SIZE-1:0] c_pq;
  logic [DATA_SIZE-1:0] c_pp;
  logic [DATA_SIZE-1:0] c_qq;
  logic                 converged;
  logic [15:0]          sweep_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, p, q, c_pq, c_pp, c_qq, converged, sweep_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, p, q, c_pq, c_pp, c_qq, converged, sweep_count
  );
endinterface

// File: rtl/pse_abs_cmp.sv
// Two's-complement magnitude and strict greater-than against the running max.
// The most-negative input maps to 2^(DATA_SIZE-1), which still fits unsigned.
module pse_abs_cmp #(
  parameter int DATA_SIZE = 8
) (
  input  logic [DATA_SIZE-1:0] data,
  input  logic [DATA_SIZE-1:0] cur_max,
  output logic [DATA_SIZE-1:0] mag,
  output logic                 gt
);
  assign mag = data[DATA_SIZE-1] ? DATA_SIZE'(~data + 1'b1) : data;
  assign gt  = mag > cur_max;
endmodule

// File: rtl/pivot_search_engine.sv
// Streaming Jacobi pivot finder: scans one row-major matrix per frame.
// Optional macro PSE_SWEEP_COUNTER_EN enables the completed-search counter.
module pivot_search_engine
  import pca_pkg::*;
#(
  parameter int          MATRIX_SIZE = 4,
  parameter int          DATA_SIZE   = 8,
  parameter int unsigned THRESHOLD   = 1,
  localparam int         IDX_W       = idx_width(MATRIX_SIZE)
) (
  input logic clk,
  input logic rst,
  pivot_search_engine_if.slave bus
);

  localparam logic [1:0]       S_IDLE   = 2'(IDLE);
  localparam logic [1:0]       S_SCAN   = 2'(SCAN);
  localparam logic [1:0]       S_RESULT = 2'(RESULT);
  localparam logic [IDX_W-1:0] LAST     = IDX_W'(MATRIX_SIZE - 1);

  logic [1:0]           state;
  logic                 ready_q;
  logic [IDX_W-1:0]     row, col;
  logic [DATA_SIZE-1:0] max_mag, mag;
  logic                 gt;
  logic [IDX_W-1:0]     best_p, best_q;
  logic [DATA_SIZE-1:0] best_val;
  logic [DATA_SIZE-1:0] diag [MATRIX_SIZE];
  logic [IDX_W-1:0]     res_p, res_q;
  logic [DATA_SIZE-1:0] res_pq, res_pp, res_qq;
  logic                 res_conv;
  logic                 accept, last_beat, first_cand, finish;
  logic [DATA_SIZE-1:0] qq_val;

  pse_abs_cmp #(.DATA_SIZE(DATA_SIZE)) u_abs (
    .data    (bus.in_data),
    .cur_max (max_mag),
    .mag     (mag),
    .gt      (gt)
  );

  assign accept     = bus.in_valid && ready_q;
  assign last_beat  = (row == LAST) && (col == LAST);
  assign first_cand = (row == '0) && (col == IDX_W'(1));
  assign finish     = accept && last_beat && (state == S_SCAN);
  // diag[N-1] arrives on the final beat itself, so forward it when q is the last index
  assign qq_val     = (best_q == LAST) ? bus.in_data : diag[best_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ready_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept) state <= S_SCAN;
        end
        S_SCAN: begin
          if (accept && last_beat) begin
            state   <= S_RESULT;
            ready_q <= 1'b0;
          end
        end
        S_RESULT: begin
          if (bus.out_ready) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row      <= '0;
      col      <= '0;
      max_mag  <= '0;
      best_p   <= '0;
      best_q   <= IDX_W'(1);
      best_val <= '0;
      for (int i = 0; i < MATRIX_SIZE; i++) diag[i] <= '0;
    end else if (accept) begin
      if (col == LAST) begin
        col <= '0;
        row <= last_beat ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      if (row == col) diag[row] <= bus.in_data;
      // (0,1) seeds each frame so no separate per-frame clear is needed
      if (first_cand || ((row < col) && gt)) begin
        max_mag  <= mag;
        best_p   <= row;
        best_q   <= col;
        best_val <= bus.in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_p    <= '0;
      res_q    <= IDX_W'(1);
      res_pq   <= '0;
      res_pp   <= '0;
      res_qq   <= '0;
      res_conv <= 1'b0;
    end else if (finish) begin
      res_p    <= best_p;
      res_q    <= best_q;
      res_pq   <= best_val;
      res_pp   <= diag[best_p];
      res_qq   <= qq_val;
      res_conv <= 32'(max_mag) < THRESHOLD;
    end
  end

`ifdef PSE_SWEEP_COUNTER_EN
  logic [15:0] sweep_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sweep_q <= '0;
    else if ((state == S_RESULT) && bus.out_ready) sweep_q <= sweep_q + 16'd1;
  end

  assign bus.sweep_count = sweep_q;
`else
  assign bus.sweep_count = 16'd0;
`endif

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = (state == S_RESULT);
  assign bus.p         = res_p;
  assign bus.q         = res_q;
  assign bus.c_pq      = res_pq;
  assign bus.c_pp      = res_pp;
  assign bus.c_qq      = res_qq;
  assign bus.converged = res_conv;

endmodule

// File: tb/tb_pivot_search_engine.sv
// Directed bench for pivot_search_engine (N=4, W=8, THRESHOLD=1) with a result scoreboard.
// Expected sweep_count follows PSE_SWEEP_COUNTER_EN when the build defines it.
module tb_pivot_search_engine;
  import pca_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   failures = 0;
  int   exp_sweep = 0;

  logic [7:0]  frame [16];
  pse_result_t exp_q [$];

  always #5 clk = ~clk;

  pivot_search_engine_if #(.MATRIX_SIZE(4), .DATA_SIZE(8)) bus ();

  pivot_search_engine #(.MATRIX_SIZE(4), .DATA_SIZE(8), .THRESHOLD(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] d0, d1, d2, d3, input logic [7:0] off);
    for (int k = 0; k < 16; k++) frame[k] = off;
    frame[0] = d0; frame[5] = d1; frame[10] = d2; frame[15] = d3;
  endtask

  // Reference search over the upper triangle in plain integer arithmetic
  function automatic pse_result_t model();
    pse_result_t r;
    int best = -1;
    int v, m;
    r.p = 2'd0; r.q = 2'd1; r.c_pq = 8'd0;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        v = int'($signed(frame[i*4+j]));
        m = (v < 0) ? -v : v;
        if (m > best) begin
          best = m; r.p = 2'(i); r.q = 2'(j); r.c_pq = frame[i*4+j];
        end
      end
    end
    r.c_pp = frame[int'(r.p)*5];
    r.c_qq = frame[int'(r.q)*5];
    r.converged = (best < 1);
    return r;
  endfunction

  task automatic drive_beat(input logic [7:0] d, input int gap);
    int guard = 0;
    @(negedge clk);
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      tests++; failures++;
      $error("[TB] FAIL in_ready_wait: observed in_ready=0 for 50 cycles, expected 1");
    end
    @(posedge clk);
  endtask

  task automatic applyStimulus(input bit bubbles);
    int gap;
    exp_q.push_back(model());
    for (int k = 0; k < 16; k++) begin
      gap = (bubbles && ($urandom_range(0, 1) == 1)) ? int'($urandom_range(1, 3)) : 0;
      drive_beat(frame[k], gap);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("latency_out_valid", 32'(bus.out_valid), 32'd1);
    check("result_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic checkOutput(input int hold);
    pse_result_t e;
    int guard = 0;
    while (!bus.out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() == 0) begin
      tests++; failures++;
      $error("[TB] FAIL scoreboard: observed empty queue, expected a pending result");
      return;
    end
    e = exp_q.pop_front();
    check("out_valid", 32'(bus.out_valid), 32'd1);
    check("p", 32'(bus.p), 32'(e.p));
    check("q", 32'(bus.q), 32'(e.q));
    check("c_pq", 32'(bus.c_pq), 32'(e.c_pq));
    check("c_pp", 32'(bus.c_pp), 32'(e.c_pp));
    check("c_qq", 32'(bus.c_qq), 32'(e.c_qq));
    check("converged", 32'(bus.converged), 32'(e.converged));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_p", 32'(bus.p), 32'(e.p));
      check("hold_q", 32'(bus.q), 32'(e.q));
      check("hold_c_pq", 32'(bus.c_pq), 32'(e.c_pq));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
`ifdef PSE_SWEEP_COUNTER_EN
    exp_sweep = (exp_sweep + 1) % 65536;
`endif
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    check("idle_hold_c_pq", 32'(bus.c_pq), 32'(e.c_pq));
    check("sweep_count", 32'(bus.sweep_count), 32'(exp_sweep));
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_p", 32'(bus.p), 32'd0);
    check("rst_q", 32'(bus.q), 32'd1);
    check("rst_c_pq", 32'(bus.c_pq), 32'd0);
    check("rst_c_pp", 32'(bus.c_pp), 32'd0);
    check("rst_c_qq", 32'(bus.c_qq), 32'd0);
    check("rst_converged", 32'(bus.converged), 32'd0);
    check("rst_sweep", 32'(bus.sweep_count), 32'd0);
    rst = 1'b0;

    fill(8'd10, 8'd20, 8'd30, 8'd40, 8'h02);
    frame[7] = 8'h30;
    applyStimulus(1'b0);
    checkOutput(0);

    fill(8'd1, 8'd2, 8'd3, 8'd4, 8'd40);
    frame[2] = 8'h9C; frame[3] = 8'hCE; frame[6] = 8'd45;
    frame[11] = 8'd50; frame[12] = 8'h7F;
    applyStimulus(1'b0);
    checkOutput(0);

    frame[6] = 8'h80;
    applyStimulus(1'b0);
    checkOutput(0);

    fill(8'd5, 8'd6, 8'd7, 8'd8, 8'd0);
    frame[1] = 8'd20; frame[11] = 8'd20;
    applyStimulus(1'b0);
    checkOutput(0);

    fill(8'd1, 8'd1, 8'd1, 8'd1, 8'd5);
    frame[6] = 8'd6; frame[12] = 8'd100;
    applyStimulus(1'b0);
    checkOutput(0);

    fill(8'd7, 8'd8, 8'd9, 8'd10, 8'd0);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b0);
      checkOutput(0);
    end

    fill(8'd10, 8'd20, 8'd30, 8'd40, 8'h02);
    frame[7] = 8'h30;
    applyStimulus(1'b1);
    checkOutput(5);

    fill(8'd11, 8'd12, 8'd13, 8'd14, 8'h7F);
    for (int k = 0; k < 7; k++) drive_beat(frame[k], 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check("midrst_sweep", 32'(bus.sweep_count), 32'd0);
    exp_sweep = 0;
    @(negedge clk);
    rst = 1'b0;
    fill(8'd3, 8'd4, 8'd5, 8'd6, 8'hF6);
    frame[11] = 8'hE0;
    applyStimulus(1'b0);
    checkOutput(0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
